l2_arbiter: RTL
===============

Name: l2_arbiter

Overview:
- Sits directly downstream of the two-port non-blocking D-cache (and the I-cache) and upstream of L2/physical memory.
- Arbitrates two line-granular clients (client 0 = I-cache, client 1 = D-cache miss/writeback path) onto the single pmem-style port.
- Latches the winning request so the downstream port sees a stable address, data and command for the whole transaction.
- Routes the one-cycle response back to the granted client only.

Parameters:
- ADDR_W, 16, address width; matches lc3b_word.
- LINE_W, 256, line width in bits; matches lc3b_32bytes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- c0_read  in  1  client 0 line read request; level, held until c0_resp.
- c0_write  in  1  client 0 line write request; level, held until c0_resp.
- c0_address  in  ADDR_W  client 0 line address.
- c0_wdata  in  LINE_W  client 0 write line.
- c0_resp  out  1  one-cycle completion pulse to client 0.
- c0_rdata  out  LINE_W  read line to client 0; valid when c0_resp=1.
- c1_read, c1_write, c1_address, c1_wdata, c1_resp, c1_rdata: same definitions as the c0_ ports, for client 1.
- l2_read  out  1  downstream read command.
- l2_write  out  1  downstream write command.
- l2_address  out  ADDR_W  latched address.
- l2_wdata  out  LINE_W  latched write line.
- l2_resp  in  1  downstream completion pulse.
- l2_rdata  in  LINE_W  downstream read line; valid with l2_resp.

Behaviour:
- States: IDLE, BUSY.
- Registers:
  - gnt: client index currently served.
  - last: client index most recently granted.
  - op_wr: latched command, 1 = write.
  - addr_q, wdata_q: latched request.
- Reset (async, rst=1):
  - state=IDLE, gnt=0, last=1 (client 0 wins the first contest), op_wr=0, addr_q=0, wdata_q=0.
  - All outputs 0: l2_read, l2_write, c0_resp, c1_resp. l2_address=0, l2_wdata=0.
- Request decode: reqN = cN_read | cN_write. If both read and write are asserted, the request is treated as a write.
- IDLE, no req: stay IDLE.
- IDLE, exactly one req: grant that client.
- IDLE, both req: grant the client != last (round-robin).
- On grant (edge):
  - Capture the winner's address and wdata into addr_q/wdata_q; op_wr = winner's cN_write.
  - gnt = winner, last = winner, state = BUSY.
- BUSY outputs:
  - l2_read = ~op_wr; l2_write = op_wr.
  - l2_address = addr_q; l2_wdata = wdata_q. Outputs are registered-stable and do not change while BUSY.
- BUSY, l2_resp=1:
  - cN_resp = 1 combinationally, same cycle, for N = gnt only; the other client's resp stays 0.
  - state = IDLE at the next edge.
- Latency:
  - Request at cycle t in IDLE → l2_read/l2_write high from t+1.
  - Client resp in the same cycle as l2_resp.
  - Minimum one IDLE cycle between transactions. The client deasserts its request the cycle after its resp, so that request is not re-granted.
- Read data: c0_rdata = c1_rdata = l2_rdata (broadcast). Clients qualify it with their own resp.
- Outputs in IDLE: l2_read = l2_write = 0; both resp = 0. l2_address/l2_wdata hold the last latched values.
- l2_resp while IDLE (spurious, or after a reset mid-transaction): ignored; no client resp.
- Client drops its request while BUSY: the transaction still completes (downstream cannot be aborted). The resp pulse is still delivered to gnt.
- Client changes address or data while BUSY: no effect; the latched copy is used.
- Reset asserted while BUSY: immediate IDLE. Outputs go to 0 asynchronously; the in-flight transaction is abandoned.
- The non-granted client waits indefinitely while BUSY. Round-robin bounds its wait to one transaction.

Decomposition:
- Package lc3b_types: add an arbiter state enum (IDLE, BUSY). Reuse lc3b_word and lc3b_32bytes for the port types.
- One sub-module: arb_rr2.
  - Inputs: req0, req1, last. Output: winner index plus valid.
  - Purely combinational two-way round-robin picker.
  - Instantiated once; the FSM and latches live in l2_arbiter.

Test Plan:
- After reset, c1_read=1 with c1_address=0x1240 → l2_read=1 and l2_address=0x1240 from the next cycle. l2_resp with l2_rdata=256'hA5..A5 → c1_resp=1 the same cycle with c1_rdata=A5..A5; c0_resp stays 0.
- c0_read (addr 0x0100) and c1_write (addr 0x2200, wdata=256'h1) both asserted from reset:
  - Client 0 is served first (last=1).
  - After c0_resp, client 1 is served with l2_write=1, l2_wdata=1.
- Both clients hold requests continuously → grants alternate 0,1,0,1 across four transactions; each l2_resp pulses exactly one resp.
- Change c1_address 0x3000→0x4000 mid-BUSY → l2_address stays 0x3000 until resp. Also c0_read=c0_write=1 → l2_write=1, l2_read=0.
- rst pulsed while BUSY → l2_read/l2_write drop to 0 immediately. A following l2_resp produces no c0_resp or c1_resp, and the arbiter is in IDLE.
- l2_resp asserted while IDLE with no requests → no resp on either client and no state change.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types.
//   lc3b_word    : 16-bit address/word
//   lc3b_32bytes : 256-bit cache line
//   arb_state_e  : L2 arbiter transaction state
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [255:0] lc3b_32bytes;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker (purely combinational).
//   req0, req1 : client requests
//   last       : index of the client most recently granted
//   winner     : index of the selected client (meaningful when valid=1)
//   valid      : at least one client is requesting
module arb_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    // Under contention the client that was not served last wins;
    // otherwise the sole requester (or 0 when nobody asks) is picked.
    if (req0 && req1) begin
      winner = ~last;
    end else begin
      winner = req1;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates the I-cache (client 0) and D-cache (client 1) line requests onto
// a single pmem-style downstream port. The winning request is latched so the
// downstream side sees a stable command/address/data for the whole transaction,
// and the one-cycle completion is routed only to the granted client.
//   clk, rst                 : clock, asynchronous active-high reset
//   cN_read/cN_write         : client N level requests (write dominates)
//   cN_address/cN_wdata      : client N line address / write line
//   cN_resp/cN_rdata         : client N completion pulse / read line
//   l2_read/l2_write         : downstream command (registered)
//   l2_address/l2_wdata      : latched address / write line
//   l2_resp/l2_rdata         : downstream completion pulse / read line
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [ADDR_W-1:0] c0_address,
  input  logic [LINE_W-1:0] c0_wdata,
  output logic              c0_resp,
  output logic [LINE_W-1:0] c0_rdata,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [ADDR_W-1:0] c1_address,
  input  logic [LINE_W-1:0] c1_wdata,
  output logic              c1_resp,
  output logic [LINE_W-1:0] c1_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata
);

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              l2_read_q, l2_read_d;
  logic              l2_write_q, l2_write_d;

  logic arb_winner;
  logic arb_valid;

  arb_rr2 u_rr (
    .req0   (c0_read | c0_write),
    .req1   (c1_read | c1_write),
    .last   (last_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    l2_read_d  = l2_read_q;
    l2_write_d = l2_write_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d    = BUSY;
          gnt_d      = arb_winner;
          last_d     = arb_winner;
          op_wr_d    = arb_winner ? c1_write   : c0_write;
          addr_d     = arb_winner ? c1_address : c0_address;
          wdata_d    = arb_winner ? c1_wdata   : c0_wdata;
          // Command flops are loaded alongside the latch so they are
          // valid in the first BUSY cycle.
          l2_read_d  = ~op_wr_d;
          l2_write_d = op_wr_d;
        end
      end
      BUSY: begin
        if (l2_resp) begin
          state_d    = IDLE;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      l2_read_q  <= l2_read_d;
      l2_write_q <= l2_write_d;
    end
  end

  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;

  // Completion is combinational from l2_resp and only honoured while BUSY,
  // so a stray pulse in IDLE never reaches a client.
  assign c0_resp  = (state_q == BUSY) & l2_resp & ~gnt_q;
  assign c1_resp  = (state_q == BUSY) & l2_resp &  gnt_q;
  assign c0_rdata = l2_rdata;
  assign c1_rdata = l2_rdata;

endmodule
